// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the P5 hazard controller: forwarding encodings,
// Tnew/Tuse constants, mult/div latencies, the shadow entry type and the
// small compare helpers used by the stall and forwarding logic.
package hazard_unit_pkg;

    // D-stage forwarding source encodings
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd3;

    // E-stage forwarding source encodings (E itself cannot be a source)
    localparam logic [1:0] EFWD_REG  = 2'd0;
    localparam logic [1:0] EFWD_M    = 2'd1;
    localparam logic [1:0] EFWD_W    = 2'd2;

    // Operand is not read by the D instruction
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew values on entry to E
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Busy cycles after a mult/div starts in E
    localparam logic [3:0] MULT_CYC_DEF = 4'd5;
    localparam logic [3:0] DIV_CYC_DEF  = 4'd10;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } shadow_t;

    // $0 is hard-wired, so it never takes part in a dependency
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] dst);
        return (r != 5'd0) && (r == dst);
    endfunction

    // Tnew one stage later, clamped at zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        logic [1:0] res;
        if (t == 2'd0) res = 2'd0;
        else           res = t - 2'd1;
        return res;
    endfunction

    // Operand r is needed within tuse cycles but E or M cannot supply it in time
    function automatic logic data_stall(input logic [4:0] r, input logic [1:0] tuse,
                                        input shadow_t e, input shadow_t m);
        logic hit;
        if (tuse == TUSE_NONE) hit = 1'b0;
        else hit = (reg_match(r, e.dst) && (e.tnew > tuse)) ||
                   (reg_match(r, m.dst) && (m.tnew > tuse));
        return hit;
    endfunction

    // D-stage source: nearest matching stage wins; not-ready nearest match reads regfile
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] r, input shadow_t e,
                                             input shadow_t m, input shadow_t w);
        logic [1:0] sel;
        if (reg_match(r, e.dst))      sel = (e.tnew == 2'd0) ? FWD_E : FWD_RF;
        else if (reg_match(r, m.dst)) sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
        else if (reg_match(r, w.dst)) sel = (w.tnew == 2'd0) ? FWD_W : FWD_RF;
        else                          sel = FWD_RF;
        return sel;
    endfunction

    // E-stage source: M before W, valid only once the producer is ready
    function automatic logic [1:0] fwd_e_sel(input logic [4:0] r, input shadow_t m,
                                             input shadow_t w);
        logic [1:0] sel;
        if (reg_match(r, m.dst))      sel = (m.tnew == 2'd0) ? EFWD_M : EFWD_REG;
        else if (reg_match(r, w.dst)) sel = (w.tnew == 2'd0) ? EFWD_W : EFWD_REG;
        else                          sel = EFWD_REG;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the P5 datapath/decoder (master) and the hazard unit (slave).
interface hazard_unit_if;

    logic [4:0] hazard_rs_D_i;
    logic [4:0] hazard_rt_D_i;
    logic [1:0] hazard_tuse_rs_D_i;
    logic [1:0] hazard_tuse_rt_D_i;
    logic [4:0] hazard_dst_D_i;
    logic [1:0] hazard_tnew_D_i;
    logic       hazard_md_D_i;
    logic       hazard_md_start_E_i;
    logic       hazard_md_div_E_i;

    logic       hazard_stall_D_o;
    logic       hazard_clr_E_o;
    logic [1:0] hazard_fwd_rs_D_o;
    logic [1:0] hazard_fwd_rt_D_o;
    logic [1:0] hazard_fwd_rs_E_o;
    logic [1:0] hazard_fwd_rt_E_o;
    logic       hazard_md_busy_o;

    modport master (
        output hazard_rs_D_i, hazard_rt_D_i, hazard_tuse_rs_D_i, hazard_tuse_rt_D_i,
               hazard_dst_D_i, hazard_tnew_D_i, hazard_md_D_i,
               hazard_md_start_E_i, hazard_md_div_E_i,
        input  hazard_stall_D_o, hazard_clr_E_o, hazard_fwd_rs_D_o, hazard_fwd_rt_D_o,
               hazard_fwd_rs_E_o, hazard_fwd_rt_E_o, hazard_md_busy_o
    );

    modport slave (
        input  hazard_rs_D_i, hazard_rt_D_i, hazard_tuse_rs_D_i, hazard_tuse_rt_D_i,
               hazard_dst_D_i, hazard_tnew_D_i, hazard_md_D_i,
               hazard_md_start_E_i, hazard_md_div_E_i,
        output hazard_stall_D_o, hazard_clr_E_o, hazard_fwd_rs_D_o, hazard_fwd_rt_D_o,
               hazard_fwd_rs_E_o, hazard_fwd_rt_E_o, hazard_md_busy_o
    );

endinterface

// File: rtl/hazard_md_cnt.sv
// Mult/div busy counter: loads the operation latency when a mult/div starts
// in E with the counter idle, then counts down to zero. A start seen while
// busy is ignored; the D-stage stall keeps that from happening.
module hazard_md_cnt
    import hazard_unit_pkg::*;
#(
    parameter logic [3:0] MULT_CYC = MULT_CYC_DEF,
    parameter logic [3:0] DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Next count: load on an idle start, otherwise decrement toward zero
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == 4'd0) begin
            if (md_start) cnt_nxt_s = md_div ? DIV_CYC : MULT_CYC;
            else          cnt_nxt_s = 4'd0;
        end else begin
            cnt_nxt_s = cnt_r - 4'd1;
        end
    end

    // Counter register, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_r <= 4'd0;
        else     cnt_r <= cnt_nxt_s;
    end

    assign md_busy = (cnt_r != 4'd0);

endmodule

// File: rtl/hazard_unit.sv
// P5 pipeline hazard controller. A shadow pipeline of {dst, tnew} for the
// instructions in E, M and W (plus rs/rt for E) drives the D-stage stall,
// the Ereg clear and the D/E forwarding selects. HI/LO instructions also
// stall while the mult/div unit is busy.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter logic [3:0] MULT_CYC = MULT_CYC_DEF,
    parameter logic [3:0] DIV_CYC  = DIV_CYC_DEF
) (
    input  logic         hazard_clk_D_i,
    input  logic         hazard_rst_D_i,
    hazard_unit_if.slave hz
);

    shadow_t    e_r;
    shadow_t    m_r;
    shadow_t    w_r;
    logic [4:0] e_rs_r;
    logic [4:0] e_rt_r;

    logic       stall_data_s;
    logic       stall_md_s;
    logic       stall_s;
    logic       md_busy_s;
    logic [1:0] fwd_rs_d_s;
    logic [1:0] fwd_rt_d_s;
    logic [1:0] fwd_rs_e_s;
    logic [1:0] fwd_rt_e_s;

    hazard_md_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_cnt (
        .clk      (hazard_clk_D_i),
        .rst      (hazard_rst_D_i),
        .md_start (hz.hazard_md_start_E_i),
        .md_div   (hz.hazard_md_div_E_i),
        .md_busy  (md_busy_s)
    );

    // Stall when an operand cannot be supplied in time or HI/LO is still being computed
    always_comb begin
        stall_data_s = data_stall(hz.hazard_rs_D_i, hz.hazard_tuse_rs_D_i, e_r, m_r) ||
                       data_stall(hz.hazard_rt_D_i, hz.hazard_tuse_rt_D_i, e_r, m_r);
        stall_md_s   = hz.hazard_md_D_i && (md_busy_s || hz.hazard_md_start_E_i);
        stall_s      = stall_data_s || stall_md_s;
    end

    // Forwarding selects for the D operands (E > M > W) and E operands (M > W)
    always_comb begin
        fwd_rs_d_s = fwd_d_sel(hz.hazard_rs_D_i, e_r, m_r, w_r);
        fwd_rt_d_s = fwd_d_sel(hz.hazard_rt_D_i, e_r, m_r, w_r);
        fwd_rs_e_s = fwd_e_sel(e_rs_r, m_r, w_r);
        fwd_rt_e_s = fwd_e_sel(e_rt_r, m_r, w_r);
    end

    // Shadow pipeline: advance every cycle, insert a bubble into E on stall
    always_ff @(posedge hazard_clk_D_i or posedge hazard_rst_D_i) begin
        if (hazard_rst_D_i) begin
            e_r    <= '{dst: 5'd0, tnew: 2'd0};
            m_r    <= '{dst: 5'd0, tnew: 2'd0};
            w_r    <= '{dst: 5'd0, tnew: 2'd0};
            e_rs_r <= 5'd0;
            e_rt_r <= 5'd0;
        end else begin
            w_r <= '{dst: m_r.dst, tnew: 2'd0};
            m_r <= '{dst: e_r.dst, tnew: tnew_dec(e_r.tnew)};
            if (stall_s) begin
                e_r    <= '{dst: 5'd0, tnew: 2'd0};
                e_rs_r <= 5'd0;
                e_rt_r <= 5'd0;
            end else begin
                e_r    <= '{dst: hz.hazard_dst_D_i, tnew: hz.hazard_tnew_D_i};
                e_rs_r <= hz.hazard_rs_D_i;
                e_rt_r <= hz.hazard_rt_D_i;
            end
        end
    end

    assign hz.hazard_stall_D_o  = stall_s;
    assign hz.hazard_clr_E_o    = stall_s;
    assign hz.hazard_fwd_rs_D_o = fwd_rs_d_s;
    assign hz.hazard_fwd_rt_D_o = fwd_rt_d_s;
    assign hz.hazard_fwd_rs_E_o = fwd_rs_e_s;
    assign hz.hazard_fwd_rt_E_o = fwd_rt_e_s;
    assign hz.hazard_md_busy_o  = md_busy_s;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Each step drives one D-stage
// instruction; a reference model of the shadow pipeline predicts the
// outputs, which are queued and compared on the following falling edge.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    typedef struct {
        int stall;
        int clr;
        int frs_d;
        int frt_d;
        int frs_e;
        int frt_e;
        int busy;
    } exp_t;

    logic clk;
    logic rst;

    hazard_unit_if hz_if();

    hazard_unit dut (
        .hazard_clk_D_i (clk),
        .hazard_rst_D_i (rst),
        .hz             (hz_if)
    );

    exp_t exp_q[$];
    int   n_chk     = 0;
    int   n_err     = 0;
    int   n_unreach = 0;
    int   obs_stall = 0;
    int   obs_busy  = 0;

    // reference model state
    logic [4:0] me_dst, me_rs, me_rt, mm_dst, mw_dst;
    logic [1:0] me_tnew, mm_tnew;
    int         mcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        me_dst = 5'd0; me_rs = 5'd0; me_rt = 5'd0; me_tnew = 2'd0;
        mm_dst = 5'd0; mm_tnew = 2'd0; mw_dst = 5'd0; mcnt = 0;
    endtask

    function automatic bit mdl_hit(input logic [4:0] r, input logic [4:0] d);
        return (r != 5'd0) && (r == d);
    endfunction

    function automatic bit mdl_late(input logic [4:0] r, input logic [1:0] u);
        if (u == 2'd3) return 1'b0;
        return (mdl_hit(r, me_dst) && me_tnew > u) || (mdl_hit(r, mm_dst) && mm_tnew > u);
    endfunction

    function automatic int mdl_dfwd(input logic [4:0] r);
        if (mdl_hit(r, me_dst)) return (me_tnew == 2'd0) ? 1 : 0;
        if (mdl_hit(r, mm_dst)) return (mm_tnew == 2'd0) ? 2 : 0;
        if (mdl_hit(r, mw_dst)) return 3;
        return 0;
    endfunction

    function automatic int mdl_efwd(input logic [4:0] r);
        if (mdl_hit(r, mm_dst)) begin
            if (mm_tnew != 2'd0) begin
                n_unreach++;
                return 0;
            end
            return 1;
        end
        if (mdl_hit(r, mw_dst)) return 2;
        return 0;
    endfunction

    function automatic exp_t model_expect(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [1:0] urs, input logic [1:0] urt,
                                          input logic md, input logic st);
        exp_t x;
        x.stall = (mdl_late(rs, urs) || mdl_late(rt, urt) || (md && (mcnt != 0 || st))) ? 1 : 0;
        x.clr   = x.stall;
        x.frs_d = mdl_dfwd(rs);
        x.frt_d = mdl_dfwd(rt);
        x.frs_e = mdl_efwd(me_rs);
        x.frt_e = mdl_efwd(me_rt);
        x.busy  = (mcnt != 0) ? 1 : 0;
        return x;
    endfunction

    task automatic model_advance(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dst, input logic [1:0] tn,
                                 input logic st, input logic dv, input int stall);
        mw_dst  = mm_dst;
        mm_dst  = me_dst;
        mm_tnew = (me_tnew == 2'd0) ? 2'd0 : me_tnew - 2'd1;
        if (stall != 0) begin
            me_dst = 5'd0; me_tnew = 2'd0; me_rs = 5'd0; me_rt = 5'd0;
        end else begin
            me_dst = dst; me_tnew = tn; me_rs = rs; me_rt = rt;
        end
        if (mcnt == 0) begin
            if (st) mcnt = dv ? 10 : 5;
        end else begin
            mcnt = mcnt - 1;
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] dst, input logic [1:0] tn,
                         input logic md, input logic st, input logic dv);
        hz_if.hazard_rs_D_i       = rs;
        hz_if.hazard_rt_D_i       = rt;
        hz_if.hazard_tuse_rs_D_i  = urs;
        hz_if.hazard_tuse_rt_D_i  = urt;
        hz_if.hazard_dst_D_i      = dst;
        hz_if.hazard_tnew_D_i     = tn;
        hz_if.hazard_md_D_i       = md;
        hz_if.hazard_md_start_E_i = st;
        hz_if.hazard_md_div_E_i   = dv;
    endtask

    task automatic compare_head(input string lbl);
        exp_t x;
        if (exp_q.size() == 0) begin
            check_val({lbl, ".queue"}, exp_q.size(), 1);
            return;
        end
        x = exp_q.pop_front();
        check_val({lbl, ".stall"},  int'(hz_if.hazard_stall_D_o),  x.stall);
        check_val({lbl, ".clr_E"},  int'(hz_if.hazard_clr_E_o),    x.clr);
        check_val({lbl, ".fwdrsD"}, int'(hz_if.hazard_fwd_rs_D_o), x.frs_d);
        check_val({lbl, ".fwdrtD"}, int'(hz_if.hazard_fwd_rt_D_o), x.frt_d);
        check_val({lbl, ".fwdrsE"}, int'(hz_if.hazard_fwd_rs_E_o), x.frs_e);
        check_val({lbl, ".fwdrtE"}, int'(hz_if.hazard_fwd_rt_E_o), x.frt_e);
        check_val({lbl, ".busy"},   int'(hz_if.hazard_md_busy_o),  x.busy);
        obs_stall = int'(hz_if.hazard_stall_D_o);
        obs_busy  = int'(hz_if.hazard_md_busy_o);
    endtask

    // One cycle: drive D at posedge+1, check at negedge, advance model at posedge
    task automatic step(input string lbl, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] urs, input logic [1:0] urt,
                        input logic [4:0] dst, input logic [1:0] tn,
                        input logic md, input logic st, input logic dv);
        exp_t x;
        drive(rs, rt, urs, urt, dst, tn, md, st, dv);
        x = model_expect(rs, rt, urs, urt, md, st);
        exp_q.push_back(x);
        @(negedge clk);
        compare_head(lbl);
        @(posedge clk);
        model_advance(rs, rt, dst, tn, st, dv, x.stall);
        #1;
    endtask

    task automatic nop(input string lbl);
        step(lbl, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int ns;
        exp_t z;
        logic [4:0] r_rs, r_rt, r_dst;
        logic [1:0] r_urs, r_urt, r_tn;
        z = '{0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #3;
        exp_q.push_back(z);
        compare_head("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        nop("idle");

        // load-use: one stall, then the add picks up the load from W in E
        step("lu_lw",     5'd0, 5'd0, 2'd3, 2'd3, 5'd8,  2'd2, 1'b0, 1'b0, 1'b0);
        step("lu_stall",  5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        step("lu_go",     5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        nop("lu_fwdE");
        nop("lu_d1"); nop("lu_d2"); nop("lu_d3");

        // ALU result needed by a branch: one stall, then forwarded from M
        step("alu_addu",  5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        step("alu_stall", 5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("alu_fwd",   5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        nop("alu_d1"); nop("alu_d2"); nop("alu_d3");

        // jal then jr $31: ready in E, no stall
        step("jal",       5'd0,  5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        step("jr",        5'd31, 5'd0, 2'd0, 2'd3, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0);
        nop("jal_d1"); nop("jal_d2"); nop("jal_d3");

        // div followed by mflo: busy 10 cycles, stall 11 (start cycle included)
        step("div_op",    5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        nb = 0; ns = 0;
        step("div_start", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b1, 1'b1);
        nb += obs_busy; ns += obs_stall;
        for (int i = 0; i < 12; i++) begin
            step("div_wait", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
            nb += obs_busy; ns += obs_stall;
        end
        check_val("div_busy_cycles",  nb, 10);
        check_val("div_stall_cycles", ns, 11);
        nop("div_d1"); nop("div_d2"); nop("div_d3");

        // mult followed by mflo: busy 5 cycles, stall 6
        step("mul_op",    5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        nb = 0; ns = 0;
        step("mul_start", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b1, 1'b0);
        nb += obs_busy; ns += obs_stall;
        for (int i = 0; i < 7; i++) begin
            step("mul_wait", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
            nb += obs_busy; ns += obs_stall;
        end
        check_val("mul_busy_cycles",  nb, 5);
        check_val("mul_stall_cycles", ns, 6);
        nop("mul_d1"); nop("mul_d2"); nop("mul_d3");

        // $0 never stalls or forwards
        step("r0_prod",   5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        step("r0_use",    5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        nop("r0_d1"); nop("r0_d2");

        // $5 in both E and M, both ready: E wins
        step("pri_m",     5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        step("pri_e",     5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
        step("pri_use",   5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        nop("pri_d1"); nop("pri_d2"); nop("pri_d3");

        // random mix of producers and consumers on a small register set
        for (int i = 0; i < 60; i++) begin
            r_urs = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
            r_urt = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
            r_rs  = (r_urs == 2'd3) ? 5'd0 : 5'($urandom_range(0, 7));
            r_rt  = (r_urt == 2'd3) ? 5'd0 : 5'($urandom_range(0, 7));
            r_dst = 5'($urandom_range(0, 7));
            r_tn  = 2'($urandom_range(0, 2));
            step("rand", r_rs, r_rt, r_urs, r_urt, r_dst, r_tn, 1'b0, 1'b0, 1'b0);
        end
        nop("rand_d1"); nop("rand_d2"); nop("rand_d3");

        // reset mid-run with E.dst=8 and counter=7
        step("rm_div",    5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        step("rm_start",  5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        nop("rm_n1");
        nop("rm_n2");
        step("rm_dst8",   5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
        check_val("rm_model_cnt", mcnt, 7);
        drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model_expect(5'd8, 5'd0, 2'd0, 2'd3, 1'b1, 1'b0));
        @(negedge clk);
        compare_head("rm_pre");
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(z);
        compare_head("rm_async");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step("rm_after",  5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        check_val("e_fwd_not_ready", n_unreach, 0);
        check_val("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage P5 CPU. It drives the Ereg clear input and the PC/Dreg freeze.
- Tracks destination register and result readiness (Tnew) of the instructions in E, M and W through its own shadow pipeline.
- Produces forwarding selects for D-stage and E-stage operands.
- Contains the mult/div busy counter that stalls dependent HI/LO instructions.

Parameters:
- MULT_CYC, 5, busy cycles after a mult starts in E
- DIV_CYC, 10, busy cycles after a div starts in E

Ports:
- hazard_clk_D_i  in  1  clock; all state updates on its rising edge
- hazard_rst_D_i  in  1  asynchronous, active-high reset
- hazard_rs_D_i  in  5  rs index of the instruction in D
- hazard_rt_D_i  in  5  rt index of the instruction in D
- hazard_tuse_rs_D_i  in  2  cycles until D needs rs (0 branch/jr, 1 ALU, 3 unused)
- hazard_tuse_rt_D_i  in  2  cycles until D needs rt (0 branch, 1 ALU, 2 store data, 3 unused)
- hazard_dst_D_i  in  5  destination register of D (0 = none)
- hazard_tnew_D_i  in  2  Tnew the D instruction will have on entering E (0 jal, 1 ALU/mfhi, 2 load)
- hazard_md_D_i  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- hazard_md_start_E_i  in  1  mult/div currently in E (start pulse)
- hazard_md_div_E_i  in  1  1 = div, 0 = mult (qualifies the start pulse)
- hazard_stall_D_o  out  1  freeze PC and Dreg
- hazard_clr_E_o  out  1  to Ereg clear; equals stall
- hazard_fwd_rs_D_o  out  2  D rs source: 0 regfile, 1 E, 2 M, 3 W
- hazard_fwd_rt_D_o  out  2  D rt source, same encoding
- hazard_fwd_rs_E_o  out  2  E rs source: 0 Ereg value, 1 M, 2 W
- hazard_fwd_rt_E_o  out  2  E rt source, same encoding
- hazard_md_busy_o  out  1  busy counter nonzero

Behaviour:
- Shadow entries E, M, W each hold {dst[4:0], tnew[1:0]}. Entry E also holds rs[4:0] and rt[4:0].
- Reset (asynchronous, immediate): all entries zero, busy counter zero.
  - Consequences: stall=0, clr_E=0, all forward selects 0, md_busy=0.
  - Reset mid-operation discards all tracked instructions and any pending mult/div count.
- Per clock edge:
  - W <= {M.dst, 0}.
  - M <= {E.dst, sat(E.tnew-1)}, where sat clamps at 0.
  - If stall: E <= all zeros (bubble, matching Ereg clear).
  - Else: E <= {dst_D, tnew_D, rs_D, rt_D}.
- Match definition: match(stage, r) = (r != 0) && (r == stage.dst).
- Data stall (combinational):
  - Condition for rs: tuse_rs != 3, and E or M matches rs with that stage's tnew > tuse_rs.
  - Same condition for rt, using tuse_rt.
  - W never stalls.
- Mult/div stall: md_D && (busy counter != 0 || md_start_E).
- stall = data stall OR mult/div stall. clr_E = stall, in the same cycle.
- D forwarding (rs, and identically rt): priority E > M > W.
  - Select the first stage that matches with tnew == 0.
  - If a nearer stage matches but has tnew > 0, select 0; stall covers that case.
  - No match gives 0.
- E forwarding: priority M > W, using E.rs / E.rt against the M and W dst.
  - The source is valid only if tnew == 0.
  - If M matches with tnew > 0, select 0. This is unreachable given the stall rule; the bench asserts it never occurs.
- Busy counter (4 bits):
  - md_start_E while counter == 0 loads MULT_CYC or DIV_CYC.
  - Otherwise a nonzero counter decrements by 1 per cycle.
  - md_start_E while counter != 0 is ignored; the stall rule prevents it.
  - md_busy = counter != 0.
- Register 0 never matches, never stalls, and never forwards.
- A stall that holds for several cycles inserts one bubble per cycle; tracked instructions ahead keep advancing.

Decomposition:
- Shared package/header holds:
  - FWD_RF, FWD_E, FWD_M, FWD_W encodings.
  - TUSE_NONE = 3.
  - Tnew constants TNEW_ALU = 1 and TNEW_LOAD = 2.
  - MULT_CYC and DIV_CYC defaults.
- One natural sub-module: hazard_md_cnt (busy counter with load/decrement).
- Shadow pipeline and compare logic stay in hazard_unit.

Test Plan:
- Reset asserted mid-run with E.dst=8 and counter=7 -> all outputs 0 immediately; next D use of $8 with tuse 0 gives stall 0, fwd 0.
- Load-use: lw $8 (tnew 2) enters E; D add uses rs=$8, tuse 1.
  - Required: stall=1 and clr_E=1 for one cycle.
  - Next cycle: M.tnew=1, stall=0.
  - Add then reaches E: fwd_rs_E=2 (W).
- ALU chain: addu $9 in E (tnew 1); D beq rt=$9, tuse 0.
  - Required: stall for one cycle.
  - Next cycle: M.tnew=0, stall=0, fwd_rt_D=2.
- jal-like dst=31, tnew 0 in E; D jr rs=31 -> no stall, fwd_rs_D=1.
- Div: md_start_E=1 with div=1, followed by D mflo.
  - Required: md_busy=1 for 10 cycles.
  - stall asserts in the start cycle and stays asserted until the counter reaches 0.
  - Repeat with mult: 5 cycles.
- Register 0 and priority cases:
  - dst=0 with D rs=0 -> never stall or forward.
  - $5 in both E (tnew 0) and M -> fwd_rs_D=1 (E wins).
